// File: rtl/vc_dest_arbiter_pkg.sv
// Shared definitions for the VC-to-destination arbiter and the main-FIFO demux:
// arbiter state encodings and the location of the destination-select bit.
package vc_dest_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_HALT  = 3'b001,
        ST_TURN0 = 3'b010,
        ST_TURN1 = 3'b100
    } arb_state_e;

    localparam int unsigned DATA_W_DEF = 6;

    // Destination select is the MSB of a transaction word.
    function automatic int unsigned dest_bit_idx(input int unsigned data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/vc_dest_arbiter.sv
// Weighted round-robin mover from the VC0/VC1 FIFOs into the D0/D1 destination
// FIFOs, steered by each word's destination bit and gated by almost-full flags.
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned WEIGHT_VC0 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active_in,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic              vc0_empty,
    output logic              vc0_pop,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              vc1_empty,
    output logic              vc1_pop,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic [DATA_W-1:0] d_data,
    output logic              d0_push,
    output logic              d1_push,
    output logic [1:0]        grant,
    output logic [1:0]        hol_blocked
);

    localparam int unsigned DEST_IDX = dest_bit_idx(DATA_W);
    localparam logic [3:0]  WEIGHT_Q = WEIGHT_VC0[3:0];

    arb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] d_data_q;
    logic              d0_push_q, d1_push_q;
    logic [1:0]        grant_q;
    logic [1:0]        hol_q, hol_d;

    logic [1:0]        af_s;
    logic              elig0_s, elig1_s;
    logic              pop0_s, pop1_s;
    logic [DATA_W-1:0] pop_word_s;

    // Eligibility, pop decode and next state/credit for the arbiter.
    always_comb begin
        af_s       = {d1_almost_full, d0_almost_full};
        elig0_s    = active_in & ~vc0_empty & ~af_s[vc0_data[DEST_IDX]];
        elig1_s    = active_in & ~vc1_empty & ~af_s[vc1_data[DEST_IDX]];
        hol_d      = {active_in & ~vc1_empty & af_s[vc1_data[DEST_IDX]],
                      active_in & ~vc0_empty & af_s[vc0_data[DEST_IDX]]};
        pop0_s     = 1'b0;
        pop1_s     = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (!reset || !active_in) begin
            state_d = ST_HALT;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_HALT: begin
                    state_d = ST_TURN0;
                    cnt_d   = 4'd0;
                end
                ST_TURN0: begin
                    if (elig0_s) begin
                        pop0_s = 1'b1;
                        if (cnt_q + 4'd1 == WEIGHT_Q) begin
                            state_d = ST_TURN1;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (elig1_s) begin
                        pop1_s = 1'b1;
                        cnt_d  = 4'd0;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_TURN1: begin
                    // VC1 owns this turn; VC0 may fill idle slots without spending credit.
                    if (elig1_s) begin
                        pop1_s  = 1'b1;
                        state_d = ST_TURN0;
                        cnt_d   = 4'd0;
                    end else if (elig0_s) begin
                        pop0_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        pop_word_s = pop1_s ? vc1_data : vc0_data;
    end

    assign vc0_pop = pop0_s;
    assign vc1_pop = pop1_s;

    // Arbiter state, credit counter and the registered destination-side outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_HALT;
            cnt_q     <= 4'd0;
            d_data_q  <= '0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            grant_q   <= 2'b00;
            hol_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hol_q   <= hol_d;
            if (pop0_s || pop1_s) begin
                d_data_q  <= pop_word_s;
                d0_push_q <= ~pop_word_s[DEST_IDX];
                d1_push_q <= pop_word_s[DEST_IDX];
                grant_q   <= {pop1_s, pop0_s};
            end else begin
                d0_push_q <= 1'b0;
                d1_push_q <= 1'b0;
                grant_q   <= 2'b00;
            end
        end
    end

    assign d_data      = d_data_q;
    assign d0_push     = d0_push_q;
    assign d1_push     = d1_push_q;
    assign grant       = grant_q;
    assign hol_blocked = hol_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Scoreboard bench for vc_dest_arbiter: bench-side VC FIFOs and a reference
// arbiter predict each cycle's pops and the registered outputs one cycle later.
module tb_vc_dest_arbiter;

    localparam int DW = 6;
    localparam int W  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          active_in;
    logic [DW-1:0] vc0_data, vc1_data;
    logic          vc0_empty, vc1_empty;
    logic          vc0_pop, vc1_pop;
    logic          d0_almost_full, d1_almost_full;
    logic [DW-1:0] d_data;
    logic          d0_push, d1_push;
    logic [1:0]    grant, hol_blocked;

    always #5 clk = ~clk;

    vc_dest_arbiter #(.DATA_W(DW), .WEIGHT_VC0(W)) dut (
        .clk(clk), .reset(reset), .active_in(active_in),
        .vc0_data(vc0_data), .vc0_empty(vc0_empty), .vc0_pop(vc0_pop),
        .vc1_data(vc1_data), .vc1_empty(vc1_empty), .vc1_pop(vc1_pop),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .d_data(d_data), .d0_push(d0_push), .d1_push(d1_push),
        .grant(grant), .hol_blocked(hol_blocked)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          p0;
        logic          p1;
        logic [1:0]    g;
        logic [1:0]    hol;
    } exp_t;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    exp_t          sb[$];
    logic [1:0]    grant_log[$];

    int            m_state;   // 0 HALT, 1 TURN0, 2 TURN1
    int            m_cnt;
    logic [DW-1:0] m_data;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // One clock cycle: predict, check pops, clock, then check registered outputs.
    task automatic step();
        exp_t e;
        logic af0, af1, e0, e1, p0, p1;
        int   ns, nc;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = vc0_empty ? 6'd0 : q0[0];
        vc1_data  = vc1_empty ? 6'd0 : q1[0];
        #1;
        af0 = vc0_data[DW-1] ? d1_almost_full : d0_almost_full;
        af1 = vc1_data[DW-1] ? d1_almost_full : d0_almost_full;
        e0  = active_in && !vc0_empty && !af0;
        e1  = active_in && !vc1_empty && !af1;
        p0 = 1'b0; p1 = 1'b0; ns = m_state; nc = m_cnt;
        if (!reset || !active_in) begin
            ns = 0; nc = 0;
        end else if (m_state == 0) begin
            ns = 1; nc = 0;
        end else if (m_state == 1) begin
            if (e0) begin
                p0 = 1'b1;
                if (m_cnt + 1 == W) begin ns = 2; nc = 0; end
                else nc = m_cnt + 1;
            end else if (e1) begin
                p1 = 1'b1; nc = 0;
            end
        end else begin
            if (e1) begin p1 = 1'b1; ns = 1; nc = 0; end
            else if (e0) p0 = 1'b1;
        end
        chk("vc0_pop", 32'(vc0_pop), 32'(p0));
        chk("vc1_pop", 32'(vc1_pop), 32'(p1));
        e = '0;
        if (!reset) begin
            m_data = '0;
        end else begin
            if (p0 || p1) begin
                m_data = p1 ? vc1_data : vc0_data;
                e.p0   = !m_data[DW-1];
                e.p1   = m_data[DW-1];
                e.g    = {p1, p0};
            end
            e.hol = {active_in && !vc1_empty && af1, active_in && !vc0_empty && af0};
        end
        e.data = m_data;
        sb.push_back(e);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        m_state = ns;
        m_cnt   = nc;
        @(negedge clk);
        e = sb.pop_front();
        chk("d_data",      32'(d_data),      32'(e.data));
        chk("d0_push",     32'(d0_push),     32'(e.p0));
        chk("d1_push",     32'(d1_push),     32'(e.p1));
        chk("grant",       32'(grant),       32'(e.g));
        chk("hol_blocked", 32'(hol_blocked), 32'(e.hol));
        grant_log.push_back(grant);
    endtask

    initial begin
        reset = 1'b0; active_in = 1'b1;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        vc0_data = '0; vc1_data = '0; vc0_empty = 1'b1; vc1_empty = 1'b1;
        m_state = 0; m_cnt = 0; m_data = '0;
        for (int i = 0; i < 12; i++) begin
            q0.push_back(6'(i));
            q1.push_back(6'(8'h10 + i));
        end
        @(negedge clk);

        // Reset held with non-empty FIFOs and active_in high.
        step(); step();
        chk("rst_grant", 32'(grant), 32'd0);

        // Weighted round-robin: VC0,VC0,VC0,VC1 after one HALT cycle.
        reset = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 9; i++) step();
        chk("wrr_halt", 32'(grant_log[0]), 32'd0);
        for (int i = 1; i < 9; i++)
            chk("wrr_seq", 32'(grant_log[i]), ((i - 1) % 4 == 3) ? 32'd2 : 32'd1);

        // VC0 empty, VC1 holding four words of mixed destination.
        q0.delete(); q1.delete();
        q1.push_back(6'h21); q1.push_back(6'h02); q1.push_back(6'h23); q1.push_back(6'h04);
        for (int i = 0; i < 6; i++) step();

        // VC0 head blocked by D1 almost-full while VC1 drains to D0.
        q0.push_back(6'h25); q0.push_back(6'h26);
        q1.push_back(6'h01); q1.push_back(6'h02); q1.push_back(6'h03);
        d1_almost_full = 1'b1;
        step();
        chk("hol_vc0", 32'(hol_blocked), 32'd1);
        step(); step();
        d1_almost_full = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // active_in dropped mid-burst, then restored.
        for (int i = 0; i < 8; i++) begin
            q0.push_back(6'(8'h08 + i));
            q1.push_back(6'(8'h28 + i));
        end
        step(); step();
        active_in = 1'b0;
        step();
        chk("act_off_pop", 32'(grant), 32'd0);
        step();
        active_in = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 5; i++) step();
        chk("react_idle", 32'(grant_log[0]), 32'd0);
        chk("react_vc0a", 32'(grant_log[1]), 32'd1);
        chk("react_vc0c", 32'(grant_log[3]), 32'd1);
        chk("react_vc1",  32'(grant_log[4]), 32'd2);

        // Reset with a push pending.
        step();
        reset = 1'b0;
        step();
        chk("rst_push", 32'(d0_push | d1_push), 32'd0);
        reset = 1'b1;
        step();
        chk("rst_halt", 32'(grant), 32'd0);

        // Random almost-full and activity traffic.
        for (int i = 0; i < 60; i++) begin
            if (q0.size() < 3) q0.push_back(6'($urandom_range(0, 63)));
            if (q1.size() < 3) q1.push_back(6'($urandom_range(0, 63)));
            d0_almost_full = ($urandom_range(0, 3) == 0);
            d1_almost_full = ($urandom_range(0, 3) == 0);
            active_in      = ($urandom_range(0, 9) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vc_dest_arbiter.md
# vc_dest_arbiter

Moves transaction words from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) of the transmission layer. Runs only while the layer controller reports ACTIVE. Shares the single output path between the VCs with weighted round-robin (VC0 favoured). Steers each word by its destination bit and honours the D FIFOs' almost-full (threshold) flags.

## Interface
- DATA_W, 6, word width; bit DATA_W-1 is the destination select (0 = D0, 1 = D1)
- WEIGHT_VC0, 3, consecutive VC0 grants allowed before VC1 is offered the turn; range 1..15

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- active_in  in  1  controller ACTIVE flag; arbitration enabled only when 1
- vc0_data  in  DATA_W  head word of VC0 FIFO (show-ahead)
- vc0_empty  in  1  VC0 FIFO empty
- vc0_pop  out  1  dequeue VC0 head this cycle (combinational)
- vc1_data  in  DATA_W  head word of VC1 FIFO (show-ahead)
- vc1_empty  in  1  VC1 FIFO empty
- vc1_pop  out  1  dequeue VC1 head this cycle (combinational)
- d0_almost_full  in  1  D0 occupancy at/above threshold
- d1_almost_full  in  1  D1 occupancy at/above threshold
- d_data  out  DATA_W  registered word to destination FIFOs
- d0_push  out  1  registered write strobe to D0
- d1_push  out  1  registered write strobe to D1
- grant  out  2  registered one-hot of the VC served last cycle ([0] = VC0)
- hol_blocked  out  2  registered; bit i = VC i non-empty but its head's destination almost-full

## Operation
- eligible_i = active_in & !vci_empty & !almost_full[vci_data[DATA_W-1]].
- At most one pop per cycle; pop only to an eligible VC.
- States (one-hot): HALT=1, TURN0=2, TURN1=4. Credit counter cnt is 4 bits.
- Any state with active_in=0: no pop; next state HALT; cnt=0.
- HALT with active_in=1: no pop this cycle; next state TURN0; cnt=0.
- TURN0:
  - elig0: pop VC0. If cnt+1 == WEIGHT_VC0, go to TURN1 with cnt=0; else cnt++.
  - else elig1: pop VC1; stay TURN0; cnt=0.
  - else: hold.
- TURN1:
  - elig1: pop VC1; go to TURN0; cnt=0.
  - else elig0: pop VC0; stay TURN1; cnt unchanged.
  - else: hold.
- Word popped from VC i is registered into d_data. Next cycle d0_push or d1_push asserts per the registered destination bit, never both. grant tracks the pop.
- No pop: d0_push = d1_push = 0, grant = 0. d_data holds its last value.
- hol_blocked_i = active_in & !vci_empty & almost_full[dest(vci_data)], registered.

## Timing
- Reset values: state HALT, cnt 0, d_data 0, d0_push 0, d1_push 0, grant 0, hol_blocked 0. Pops are 0 while reset=0.
- Pop at cycle N produces the push at cycle N+1 (latency 1). Throughput is 1 word/cycle.
- Almost-full thresholds must leave at least 1 free entry, to absorb the in-flight word.
- active_in falling at cycle N: no pop at N. A word popped at N-1 is still pushed at N.
- Reset asserted at cycle N: the push registers clear at N+1 and the in-flight word is dropped. The FIFOs are reset by the same signal.
- First pop after active_in rises: 1 cycle later, because of the pass through HALT.

## Structure
- Shared package holds the state encodings (HALT, TURN0, TURN1) and the destination-bit index constant, reused by the main-FIFO demux.
- Single module; no sub-module. Eligibility and pop decode are one combinational block; state, cnt and output registers are one sequential block.

## Test plan
1. Hold reset=0 for 2 cycles, with FIFOs non-empty and active_in=1 -> all outputs 0, no pops.
2. Both VCs full, all heads dest D0, WEIGHT_VC0=3, no almost-full -> grant sequence VC0,VC0,VC0,VC1 repeating; d0_push=1 every cycle starting 1 cycle after the first pop.
3. VC0 empty, VC1 holding 4 words -> vc1_pop for 4 consecutive cycles; words appear on d_data in order.
4. VC0 head dest D1 with d1_almost_full=1, VC1 head dest D0 -> only VC1 popped; hol_blocked=2'b01 one cycle later; VC0 resumes the cycle after d1_almost_full drops.
5. active_in deasserted mid-burst -> pops stop the same cycle; the last popped word is pushed next cycle. On reassertion: one idle cycle, then a VC0 grant with cnt restarting at 0.
6. Reset asserted while a push is pending -> d0_push and d1_push are 0 the next cycle; state is HALT.
